// File: rtl/regfile_sb.sv
// Parametrised two-read/one-write register file with registered reads, optional
// write-to-read bypass, optional hard-wired zero register and a per-register busy scoreboard.
module regfile_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic              we,
   input  logic [DATA_W-1:0] wd,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_a,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] rf_q [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic              rd1_busy_q, rd1_busy_d, rd2_busy_q, rd2_busy_d;
   logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
   logic              wr_en;

   function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      if (ZERO_REG != 0 && a == '0)
         return '0;
      else if (BYPASS != 0 && wr_en && a3 == a)
         return wd;
      else
         return rf_q[a];
   endfunction

   // A write to the hard-wired zero register is simply discarded.
   assign wr_en = we && !(ZERO_REG != 0 && a3 == '0);

   always_comb begin
      busy_d = busy_q;
      if (we)     busy_d[a3]    = 1'b0;
      // Reservation applied last so a new producer supersedes a completing one.
      if (rsv_en) busy_d[rsv_a] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;

      rd1_d = read_port(a1);
      rd2_d = read_port(a2);
      if (BYPASS != 0) begin
         rd1_busy_d = busy_d[a1];
         rd2_busy_d = busy_d[a2];
      end else begin
         rd1_busy_d = busy_q[a1];
         rd2_busy_d = busy_q[a2];
      end
      busy_cnt_d = popcount(busy_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= (ZERO_REG != 0 && i == 0) ? '0 : DATA_W'(i + 1);
         busy_q     <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         rd1_busy_q <= 1'b0;
         rd2_busy_q <= 1'b0;
         busy_cnt_q <= '0;
      end else begin
         if (wr_en) rf_q[a3] <= wd;
         busy_q     <= busy_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         rd1_busy_q <= rd1_busy_d;
         rd2_busy_q <= rd2_busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign rd1      = rd1_q;
   assign rd2      = rd2_q;
   assign rd1_busy = rd1_busy_q;
   assign rd2_busy = rd2_busy_q;
   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three configurations share one stimulus bus; expected
// values are queued with their due cycle and a negedge monitor pops and compares them.
module tb_regfile_sb;

   localparam int DW = 8;
   localparam int AW = 3;

   localparam int F_RD1 = 0, F_RD2 = 1, F_B1 = 2, F_B2 = 3, F_CNT = 4;

   typedef struct packed {
      int         due;
      int         tid;
      logic [1:0] sel;
      logic [2:0] fld;
      logic [7:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, we, rsv_en;
   logic [AW-1:0] a1, a2, a3, rsv_a;
   logic [DW-1:0] wd;

   logic [DW-1:0] rd1_o [3];
   logic [DW-1:0] rd2_o [3];
   logic          b1_o  [3];
   logic          b2_o  [3];
   logic [AW:0]   cnt_o [3];

   exp_t exp_q [$];
   int   cyc = 0;
   int   tid = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // dut 0: bypass, dut 1: no bypass, dut 2: bypass with zero register
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(0)) u_byp (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we(we), .wd(wd),
      .rsv_en(rsv_en), .rsv_a(rsv_a), .rd1(rd1_o[0]), .rd2(rd2_o[0]),
      .rd1_busy(b1_o[0]), .rd2_busy(b2_o[0]), .busy_cnt(cnt_o[0]));

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we(we), .wd(wd),
      .rsv_en(rsv_en), .rsv_a(rsv_a), .rd1(rd1_o[1]), .rd2(rd2_o[1]),
      .rd1_busy(b1_o[1]), .rd2_busy(b2_o[1]), .busy_cnt(cnt_o[1]));

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) u_zero (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we(we), .wd(wd),
      .rsv_en(rsv_en), .rsv_a(rsv_a), .rd1(rd1_o[2]), .rd2(rd2_o[2]),
      .rd1_busy(b1_o[2]), .rd2_busy(b2_o[2]), .busy_cnt(cnt_o[2]));

   function automatic logic [7:0] actual(input int s, input int f);
      case (f)
         F_RD1:   return rd1_o[s];
         F_RD2:   return rd2_o[s];
         F_B1:    return {7'd0, b1_o[s]};
         F_B2:    return {7'd0, b2_o[s]};
         default: return {4'd0, cnt_o[s]};
      endcase
   endfunction

   function automatic string fname(input int f);
      case (f)
         F_RD1:   return "rd1";
         F_RD2:   return "rd2";
         F_B1:    return "rd1_busy";
         F_B2:    return "rd2_busy";
         default: return "busy_cnt";
      endcase
   endfunction

   // Monitor: outputs registered at the preceding rising edge are compared here.
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] act;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e   = exp_q.pop_front();
         act = actual(int'(e.sel), int'(e.fld));
         n_chk++;
         if (e.due != cyc || act !== e.val) begin
            n_fail++;
            $display("FAIL t%0d dut%0d %s: got %0h, expected %0h (due %0d, now %0d)",
                     e.tid, e.sel, fname(int'(e.fld)), act, e.val, e.due, cyc);
         end
      end
   end

   task automatic exp_push(input int s, input int f, input int v);
      exp_t e;
      e.due = cyc + 1;
      e.tid = tid;
      e.sel = s[1:0];
      e.fld = f[2:0];
      e.val = v[7:0];
      exp_q.push_back(e);
   endtask

   task automatic idle();
      reset = 1'b0; we = 1'b0; rsv_en = 1'b0;
      a1 = '0; a2 = '0; a3 = '0; rsv_a = '0; wd = '0;
   endtask

   task automatic next();
      @(negedge clk);
      #1;
   endtask

   int cnt_b [8]  = '{2, 3, 4, 5, 6, 6, 7, 8};
   int cnt_z [8]  = '{1, 2, 3, 4, 5, 5, 6, 7};

   initial begin
      idle();
      reset = 1'b1;
      next();

      // reset state
      tid = 1;
      reset = 1'b1; a1 = 3'd5; a2 = 3'd6; we = 1'b1; a3 = 3'd5; wd = 8'h99; rsv_en = 1'b1; rsv_a = 3'd6;
      exp_push(0, F_RD1, 0); exp_push(0, F_RD2, 0);
      exp_push(0, F_B1, 0);  exp_push(0, F_B2, 0); exp_push(0, F_CNT, 0);
      next();

      // default contents
      tid = 2;
      idle();
      for (int i = 0; i < 8; i++) begin
         a1 = i[AW-1:0];
         exp_push(0, F_RD1, i + 1);
         if (i == 0) exp_push(2, F_RD1, 0);
         if (i == 7) exp_push(0, F_CNT, 0);
         next();
      end

      // same-cycle write and read: bypass versus registered-before-edge
      tid = 3;
      we = 1'b1; a3 = 3'd2; wd = 8'hA5; a1 = 3'd2;
      exp_push(0, F_RD1, 8'hA5); exp_push(1, F_RD1, 8'h03);
      next();
      we = 1'b0;
      exp_push(0, F_RD1, 8'hA5); exp_push(1, F_RD1, 8'hA5); exp_push(0, F_CNT, 0);
      next();

      // reserve, observe busy, then retire with a write
      tid = 4;
      rsv_en = 1'b1; rsv_a = 3'd4; a1 = 3'd0; a2 = 3'd0;
      exp_push(0, F_CNT, 1); exp_push(1, F_CNT, 1);
      next();
      rsv_en = 1'b0; a2 = 3'd4;
      exp_push(0, F_B2, 1); exp_push(1, F_B2, 1); exp_push(0, F_CNT, 1);
      next();
      we = 1'b1; a3 = 3'd4; wd = 8'h3C;
      exp_push(0, F_RD2, 8'h3C); exp_push(0, F_B2, 0); exp_push(0, F_CNT, 0);
      exp_push(1, F_RD2, 8'h05); exp_push(1, F_B2, 1); exp_push(1, F_CNT, 0);
      next();
      we = 1'b0;

      // reserve and write the same register in one cycle: set wins
      tid = 5;
      rsv_en = 1'b1; rsv_a = 3'd5; we = 1'b1; a3 = 3'd5; wd = 8'h5A; a1 = 3'd5;
      exp_push(0, F_RD1, 8'h5A); exp_push(0, F_B1, 1); exp_push(0, F_CNT, 1);
      exp_push(1, F_RD1, 8'h06); exp_push(1, F_B1, 0); exp_push(1, F_CNT, 1);
      next();
      rsv_en = 1'b0; we = 1'b0;
      exp_push(1, F_RD1, 8'h5A); exp_push(1, F_B1, 1); exp_push(0, F_CNT, 1);
      next();

      // fill the scoreboard, then one more reservation saturates at NREG
      tid = 6;
      rsv_en = 1'b1; a1 = 3'd7;
      for (int r = 0; r < 8; r++) begin
         rsv_a = r[AW-1:0];
         exp_push(0, F_CNT, cnt_b[r]);
         exp_push(2, F_CNT, cnt_z[r]);
         next();
      end
      rsv_a = 3'd3;
      exp_push(0, F_CNT, 8); exp_push(0, F_B1, 1); exp_push(2, F_CNT, 7);
      next();

      // reset during a pending write and reservation
      tid = 7;
      reset = 1'b1; we = 1'b1; a3 = 3'd3; wd = 8'hEE; rsv_en = 1'b1; rsv_a = 3'd2;
      exp_push(0, F_CNT, 0); exp_push(0, F_B1, 0); exp_push(1, F_CNT, 0);
      next();
      idle(); a1 = 3'd3; a2 = 3'd2;
      exp_push(0, F_RD1, 8'h04); exp_push(1, F_RD1, 8'h04);
      exp_push(0, F_RD2, 8'h03); exp_push(0, F_CNT, 0);
      next();

      // register 0: hard-wired versus ordinary
      tid = 8;
      we = 1'b1; a3 = 3'd0; wd = 8'hFF; rsv_en = 1'b1; rsv_a = 3'd0; a1 = 3'd0;
      exp_push(2, F_RD1, 8'h00); exp_push(2, F_B1, 0); exp_push(2, F_CNT, 0);
      exp_push(0, F_RD1, 8'hFF); exp_push(0, F_B1, 1); exp_push(0, F_CNT, 1);
      next();
      we = 1'b0; rsv_en = 1'b0;
      exp_push(2, F_RD1, 8'h00); exp_push(2, F_B1, 0); exp_push(2, F_CNT, 0);
      exp_push(1, F_RD1, 8'hFF); exp_push(1, F_B1, 1); exp_push(1, F_CNT, 1);
      next();

      idle();
      repeat (3) next();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
